// File: rtl/disp_src_sched.sv
// ---------------------------------------------------------------------------
// disp_src_sched : display-source select scheduler (computer / auto-scan / switches)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module disp_src_sched #(
  parameter int DWELL_TICKS = 1000,
  parameter int CW          = 16,
  parameter int DIRECT_SEL  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [3:0]  sw_sel,
  input  logic        comp_req,
  input  logic [3:0]  comp_sel,
  input  logic [15:0] scan_mask,
  input  logic        btn_next,
  input  logic        btn_scan,
  output logic [3:0]  sel,
  output logic [1:0]  mode,
  output logic        direct,
  output logic        changed
);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_COMP   = 2'd2
  } mode_e;

  localparam logic [CW-1:0] C_DWELL_LAST = CW'(DWELL_TICKS - 1);
  localparam logic [3:0]    C_DIRECT     = 4'(DIRECT_SEL);

  mode_e        mode_q, mode_d;
  logic [3:0]   sel_q, sel_d;
  logic [3:0]   saved_q, saved_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         direct_q, changed_q;
  logic         scan_en_q, scan_en_d;
  logic         next_prev_q, scan_prev_q, armed_q;
  logic         pre_scan_q, pre_scan_d;
  logic         en_at_comp_q, en_at_comp_d;
  logic         w_next_edge, w_scan_edge, w_advance;

  // First set bit of m at or above s, wrapping 15 -> 0; s if m is empty.
  function automatic logic [3:0] find_from(input logic [15:0] m, input logic [3:0] s);
    logic [3:0] r;
    logic [3:0] idx;
    logic       found;
    r     = s;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = s + 4'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // armed_q masks edges on the first clock after reset so a held button is ignored.
  assign w_next_edge = armed_q & btn_next & ~next_prev_q;
  assign w_scan_edge = armed_q & btn_scan & ~scan_prev_q;
  assign w_advance   = (tick && cnt_q == C_DWELL_LAST) || w_next_edge;

  always_comb begin
    scan_en_d    = scan_en_q ^ w_scan_edge;
    sel_d        = sel_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    pre_scan_d   = pre_scan_q;
    en_at_comp_d = en_at_comp_q;

    if (comp_req)                              mode_d = MODE_COMP;
    else if (scan_en_d && scan_mask != 16'h0)  mode_d = MODE_SCAN;
    else                                       mode_d = MODE_MANUAL;

    case (mode_d)
      MODE_COMP: begin
        sel_d = comp_sel;
        if (mode_q != MODE_COMP) begin
          pre_scan_d   = (mode_q == MODE_SCAN);
          en_at_comp_d = scan_en_q;
        end
      end
      MODE_SCAN: begin
        if (mode_q == MODE_MANUAL) begin
          sel_d = find_from(scan_mask, sel_q);
          cnt_d = '0;
        end else if (mode_q == MODE_COMP) begin
          // Resume the frozen position unless scan was re-enabled while in COMP.
          if (pre_scan_q && (scan_en_q == en_at_comp_q))
            sel_d = find_from(scan_mask, saved_q);
          else
            sel_d = find_from(scan_mask, sel_q);
          cnt_d = '0;
        end else if (!scan_mask[sel_q]) begin
          sel_d = find_from(scan_mask, sel_q);
          cnt_d = '0;
        end else if (w_advance) begin
          sel_d = find_from(scan_mask, sel_q + 4'd1);
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = cnt_q + CW'(1);
        end
        saved_d = sel_d;
      end
      default: begin
        sel_d = sw_sel;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_MANUAL;
      sel_q        <= 4'd0;
      saved_q      <= 4'd0;
      cnt_q        <= '0;
      direct_q     <= 1'b0;
      changed_q    <= 1'b0;
      scan_en_q    <= 1'b0;
      next_prev_q  <= 1'b0;
      scan_prev_q  <= 1'b0;
      armed_q      <= 1'b0;
      pre_scan_q   <= 1'b0;
      en_at_comp_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      direct_q     <= (sel_d == C_DIRECT);
      changed_q    <= (sel_d != sel_q);
      scan_en_q    <= scan_en_d;
      next_prev_q  <= btn_next;
      scan_prev_q  <= btn_scan;
      armed_q      <= 1'b1;
      pre_scan_q   <= pre_scan_d;
      en_at_comp_q <= en_at_comp_d;
    end
  end

  assign sel     = sel_q;
  assign mode    = mode_q;
  assign direct  = direct_q;
  assign changed = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_src_sched.sv
// ---------------------------------------------------------------------------
// tb_disp_src_sched : directed scoreboard bench for disp_src_sched (DWELL_TICKS=3)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_disp_src_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  sw_sel;
  logic        comp_req;
  logic [3:0]  comp_sel;
  logic [15:0] scan_mask;
  logic        btn_next;
  logic        btn_scan;
  logic [3:0]  sel;
  logic [1:0]  mode;
  logic        direct;
  logic        changed;

  int checks = 0;
  int errors = 0;

  // Expected {sel, mode, direct, changed} plus a tag, queued at drive time.
  logic [7:0] exp_q[$];
  string      tag_q[$];

  disp_src_sched #(.DWELL_TICKS(3), .CW(16), .DIRECT_SEL(10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .sw_sel(sw_sel),
    .comp_req(comp_req), .comp_sel(comp_sel), .scan_mask(scan_mask),
    .btn_next(btn_next), .btn_scan(btn_scan),
    .sel(sel), .mode(mode), .direct(direct), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] s, input logic [1:0] m,
                      input logic d, input logic c);
    exp_q.push_back({s, m, d, c});
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [7:0] e;
    logic [7:0] o;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {sel, mode, direct, changed};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed sel/mode/dir/chg=%h/%h/%b/%b expected %h/%h/%b/%b",
             t, o[7:4], o[3:2], o[1], o[0], e[7:4], e[3:2], e[1], e[0]);
    end
  endtask

  // Expect the outputs after the next rising edge; inputs stay as currently driven.
  task automatic cyc(input string tag, input logic [3:0] s, input logic [1:0] m,
                     input logic d, input logic c);
    push(tag, s, m, d, c);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic now(input string tag, input logic [3:0] s, input logic [1:0] m,
                     input logic d, input logic c);
    push(tag, s, m, d, c);
    pop_check();
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; sw_sel = 4'd3; comp_req = 1'b0; comp_sel = 4'd0;
    scan_mask = 16'h0; btn_next = 1'b0; btn_scan = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    now("reset_state", 4'd0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("manual_sw3", 4'd3, 2'd0, 1'b0, 1'b1);
    cyc("manual_hold", 4'd3, 2'd0, 1'b0, 1'b0);

    // Auto-scan over mask 0x13, one tick per cycle.
    sw_sel = 4'd0;
    cyc("manual_sw0", 4'd0, 2'd0, 1'b0, 1'b1);
    scan_mask = 16'h0013; btn_scan = 1'b1;
    cyc("scan_entry", 4'd0, 2'd1, 1'b0, 1'b0);
    btn_scan = 1'b0; tick = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc("dwell_a", r == 0 ? 4'd0 : r == 1 ? 4'd1 : 4'd4, 2'd1, 1'b0, 1'b0);
      cyc("dwell_b", r == 0 ? 4'd0 : r == 1 ? 4'd1 : 4'd4, 2'd1, 1'b0, 1'b0);
      cyc("scan_step", r == 0 ? 4'd1 : r == 1 ? 4'd4 : 4'd0, 2'd1, 1'b0, 1'b1);
    end
    cyc("dwell_a", 4'd0, 2'd1, 1'b0, 1'b0);
    cyc("dwell_b", 4'd0, 2'd1, 1'b0, 1'b0);
    cyc("scan_step", 4'd1, 2'd1, 1'b0, 1'b1);
    cyc("dwell_1tick", 4'd1, 2'd1, 1'b0, 1'b0);

    // Computer override to the direct-pixel select, then resume at sel 1.
    tick = 1'b0; comp_req = 1'b1; comp_sel = 4'd10;
    cyc("comp_enter", 4'd10, 2'd2, 1'b1, 1'b1);
    cyc("comp_hold", 4'd10, 2'd2, 1'b1, 1'b0);
    comp_req = 1'b0;
    cyc("comp_leave", 4'd1, 2'd1, 1'b0, 1'b1);
    tick = 1'b1;
    cyc("resume_t1", 4'd1, 2'd1, 1'b0, 1'b0);
    cyc("resume_t2", 4'd1, 2'd1, 1'b0, 1'b0);
    cyc("resume_adv", 4'd4, 2'd1, 1'b0, 1'b1);
    cyc("dwell_a", 4'd4, 2'd1, 1'b0, 1'b0);
    cyc("dwell_b", 4'd4, 2'd1, 1'b0, 1'b0);
    cyc("scan_step", 4'd0, 2'd1, 1'b0, 1'b1);
    cyc("dwell_a", 4'd0, 2'd1, 1'b0, 1'b0);
    cyc("dwell_b", 4'd0, 2'd1, 1'b0, 1'b0);

    // Dwell expiry coincident with a btn_next edge: one step only.
    btn_next = 1'b1;
    cyc("dual_trigger", 4'd1, 2'd1, 1'b0, 1'b1);
    tick = 1'b0;
    cyc("btn_held", 4'd1, 2'd1, 1'b0, 1'b0);
    btn_next = 1'b0;
    cyc("btn_low", 4'd1, 2'd1, 1'b0, 1'b0);

    // Mask drops sel bit: move to the only remaining bit, then self-advance.
    scan_mask = 16'h0020;
    cyc("mask_change", 4'd5, 2'd1, 1'b0, 1'b1);
    tick = 1'b1;
    cyc("single_t1", 4'd5, 2'd1, 1'b0, 1'b0);
    cyc("single_t2", 4'd5, 2'd1, 1'b0, 1'b0);
    cyc("single_adv", 4'd5, 2'd1, 1'b0, 1'b0);
    tick = 1'b0; scan_mask = 16'h0; sw_sel = 4'd7;
    cyc("mask_zero", 4'd7, 2'd0, 1'b0, 1'b1);
    scan_mask = 16'h0013;
    cyc("mask_back_wrap", 4'd0, 2'd1, 1'b0, 1'b1);
    btn_next = 1'b1;
    cyc("btn_next_adv", 4'd1, 2'd1, 1'b0, 1'b1);

    // Asynchronous reset between edges, with btn_scan held through release.
    btn_next = 1'b0; btn_scan = 1'b1; tick = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    now("async_reset", 4'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_reset", 4'd7, 2'd0, 1'b0, 1'b1);
    cyc("held_btn_no_edge", 4'd7, 2'd0, 1'b0, 1'b0);
    btn_scan = 1'b0;
    cyc("btn_release", 4'd7, 2'd0, 1'b0, 1'b0);
    btn_scan = 1'b1;
    cyc("scan_reenter", 4'd0, 2'd1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no end of stimulus, required completion within 100000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
